// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if
//   Bundle between the five-stage pipeline registers and the hazard controller.
//   Fields read from the pipeline registers:
//     id_rs, id_rt, id_uses_rt           IF/ID source registers and rt-read flag
//     ex_rs, ex_rt, ex_rd                ID/EX source/destination registers
//     ex_regwrite, ex_memread            ID/EX control bits
//     mem_rd, mem_regwrite               EX/MEM destination and write bit
//     wb_rd, wb_regwrite                 MEM/WB destination and write bit
//     mem_branch_taken                   EX/MEM branch AND zero
//   Controls driven back by the hazard controller:
//     pc_we, if_id_we                    load enables
//     if_id_flush, id_ex_flush,
//     ex_mem_flush                       bubble insertion
//     fwd_a, fwd_b                       ALU operand source selects
//   Handshake: none; every control is a level valid in the current cycle and
//   is consumed by the pipeline registers on the next rising clock edge.
//   modport master: the hazard controller.  modport slave: the pipeline side.
interface pipe_hazard_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic [4:0] wb_rd;
    logic       wb_regwrite;
    logic       mem_branch_taken;
    logic       pc_we;
    logic       if_id_we;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    modport master (
        input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd,
        input  ex_regwrite, ex_memread, mem_rd, mem_regwrite,
        input  wb_rd, wb_regwrite, mem_branch_taken,
        output pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush,
        output fwd_a, fwd_b
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd,
        output ex_regwrite, ex_memread, mem_rd, mem_regwrite,
        output wb_rd, wb_regwrite, mem_branch_taken,
        input  pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush,
        input  fwd_a, fwd_b
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard detection, stall/flush control and EX operand forwarding for the
//   five-stage MIPS pipeline, with saturating stall/flush event counters.
//   Build option: define PIPE_FORWARD_EN to enable forwarding (only load-use
//   stalls, one cycle). Left undefined, forwarding selects are tied to 00 and
//   every RAW hazard stalls (ID/EX producer: 2 cycles, EX/MEM producer: 1).
//   Ports:
//     clk            pipeline clock, rising edge
//     rst_n          asynchronous active-low reset
//     hif            pipe_hazard_if.master (pipeline fields in, controls out)
//     stall_cnt      saturating count of stall cycles
//     flush_cnt      saturating count of taken-branch flushes
//     dbg_state      1 while the FSM is in STALL
//     dbg_stall_left remaining STALL cycles
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_if.master     hif,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              dbg_state,
    output logic [1:0]        dbg_stall_left
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    state_t     state;
    logic [1:0] stall_left;
    logic [1:0] need;        // stall cycles required by the current IF/ID instruction
    logic       stalling;

    // Producer matches; $0 never matches and the producer must write.
    logic ex_hit;
    logic mem_hit;
    assign ex_hit  = hif.ex_regwrite && (hif.ex_rd != 5'd0) &&
                     ((hif.ex_rd == hif.id_rs) ||
                      (hif.id_uses_rt && (hif.ex_rd == hif.id_rt)));
    assign mem_hit = hif.mem_regwrite && (hif.mem_rd != 5'd0) &&
                     ((hif.mem_rd == hif.id_rs) ||
                      (hif.id_uses_rt && (hif.mem_rd == hif.id_rt)));

`ifdef PIPE_FORWARD_EN
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;

    // Only a load result cannot be forwarded in time.
    always_comb begin
        need = 2'd0;
        if (hif.ex_memread && ex_hit) need = 2'd1;
    end

    // EX/MEM is checked first so the youngest producer wins a double match.
    always_comb begin
        fwd_a_sel = 2'b00;
        if (hif.mem_regwrite && (hif.mem_rd != 5'd0) && (hif.mem_rd == hif.ex_rs))
            fwd_a_sel = 2'b10;
        else if (hif.wb_regwrite && (hif.wb_rd != 5'd0) && (hif.wb_rd == hif.ex_rs))
            fwd_a_sel = 2'b01;
    end

    always_comb begin
        fwd_b_sel = 2'b00;
        if (hif.mem_regwrite && (hif.mem_rd != 5'd0) && (hif.mem_rd == hif.ex_rt))
            fwd_b_sel = 2'b10;
        else if (hif.wb_regwrite && (hif.wb_rd != 5'd0) && (hif.wb_rd == hif.ex_rt))
            fwd_b_sel = 2'b01;
    end
`else
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       unused_fwd_inputs;

    // MEM/WB producers are covered by the write-first register file.
    always_comb begin
        need = 2'd0;
        if (ex_hit)       need = 2'd2;
        else if (mem_hit) need = 2'd1;
    end

    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
    assign unused_fwd_inputs = ^{hif.ex_rs, hif.ex_rt, hif.wb_rd,
                                 hif.wb_regwrite, hif.ex_memread};
`endif

    assign stalling = (state == STALL) || (need != 2'd0);

    // Control outputs are combinational from inputs and state.
    always_comb begin
        hif.pc_we        = 1'b1;
        hif.if_id_we     = 1'b1;
        hif.if_id_flush  = 1'b0;
        hif.id_ex_flush  = 1'b0;
        hif.ex_mem_flush = 1'b0;
        hif.fwd_a        = fwd_a_sel;
        hif.fwd_b        = fwd_b_sel;
        if (!rst_n) begin
            hif.pc_we        = 1'b0;
            hif.if_id_we     = 1'b0;
            hif.if_id_flush  = 1'b1;
            hif.id_ex_flush  = 1'b1;
            hif.ex_mem_flush = 1'b1;
            hif.fwd_a        = 2'b00;
            hif.fwd_b        = 2'b00;
        end else if (hif.mem_branch_taken) begin
            // Branch outranks any stall: squash the three younger stages.
            hif.if_id_flush  = 1'b1;
            hif.id_ex_flush  = 1'b1;
            hif.ex_mem_flush = 1'b1;
        end else if (stalling) begin
            hif.pc_we        = 1'b0;
            hif.if_id_we     = 1'b0;
            hif.id_ex_flush  = 1'b1;
        end
    end

    // FSM and counters. In STALL the inputs are not re-evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            stall_left <= 2'd0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else if (hif.mem_branch_taken) begin
            state      <= RUN;
            stall_left <= 2'd0;
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end else if (state == STALL) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (stall_left <= 2'd1) begin
                state      <= RUN;
                stall_left <= 2'd0;
            end else begin
                stall_left <= stall_left - 2'd1;
            end
        end else if (need != 2'd0) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (need > 2'd1) begin
                state      <= STALL;
                stall_left <= need - 2'd1;
            end
        end
    end

    assign dbg_state      = (state == STALL);
    assign dbg_stall_left = stall_left;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl; expectations depend on whether
//   PIPE_FORWARD_EN is defined for the build.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             dbg_state;
    logic [1:0]       dbg_stall_left;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipe_hazard_if hif();

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hif            (hif.master),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
        .dbg_state      (dbg_state),
        .dbg_stall_left (dbg_stall_left)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        hif.id_rs = 5'd0;  hif.id_rt = 5'd0;  hif.id_uses_rt = 1'b0;
        hif.ex_rs = 5'd0;  hif.ex_rt = 5'd0;  hif.ex_rd = 5'd0;
        hif.ex_regwrite = 1'b0;  hif.ex_memread = 1'b0;
        hif.mem_rd = 5'd0; hif.mem_regwrite = 1'b0;
        hif.wb_rd = 5'd0;  hif.wb_regwrite = 1'b0;
        hif.mem_branch_taken = 1'b0;
    endtask

    // Advance one clock; inputs are then changed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lw $3 in ID/EX feeding the IF/ID instruction: a hazard in both builds.
    task automatic drive_hazard();
        clear_inputs();
        hif.ex_rd = 5'd3; hif.ex_regwrite = 1'b1; hif.ex_memread = 1'b1;
        hif.id_rs = 5'd3; hif.id_rt = 5'd4; hif.id_uses_rt = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if ({hif.pc_we, hif.if_id_we} !== 2'b00) begin
            errors++; $display("FAIL reset_we: got %b want 00", {hif.pc_we, hif.if_id_we});
        end
        checks++;
        if ({hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush} !== 3'b111) begin
            errors++; $display("FAIL reset_flush: got %b want 111",
                               {hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush});
        end
        checks++;
        if ({hif.fwd_a, hif.fwd_b} !== 4'b0000) begin
            errors++; $display("FAIL reset_fwd: got %b want 0000", {hif.fwd_a, hif.fwd_b});
        end
        checks++;
        if ({stall_cnt, flush_cnt, dbg_state, dbg_stall_left} !== '0) begin
            errors++; $display("FAIL reset_state: stall %0h flush %0h st %b left %0d want all 0",
                               stall_cnt, flush_cnt, dbg_state, dbg_stall_left);
        end
    endtask

    task automatic test_idle();
        clear_inputs();
        hif.id_rs = 5'd1; hif.id_rt = 5'd2; hif.id_uses_rt = 1'b1;
        #1;
        checks++;
        if ({hif.pc_we, hif.if_id_we, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush} !== 5'b11000) begin
            errors++; $display("FAIL idle_ctrl: got %b want 11000",
                               {hif.pc_we, hif.if_id_we, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush});
        end
        tick();
    endtask

    task automatic test_hazard();
`ifdef PIPE_FORWARD_EN
        // lw $2 in ID/EX, add $3,$2,$4 in IF/ID
        clear_inputs();
        hif.ex_rd = 5'd2; hif.ex_regwrite = 1'b1; hif.ex_memread = 1'b1;
        hif.id_rs = 5'd2; hif.id_rt = 5'd4; hif.id_uses_rt = 1'b1;
        #1;
        checks++;
        if ({hif.pc_we, hif.if_id_we, hif.id_ex_flush, hif.if_id_flush} !== 4'b0010) begin
            errors++; $display("FAIL loaduse_stall: got %b want 0010",
                               {hif.pc_we, hif.if_id_we, hif.id_ex_flush, hif.if_id_flush});
        end
        tick(); exp_stall++;
        clear_inputs();   // bubble now in ID/EX
        hif.id_rs = 5'd2; hif.id_rt = 5'd4; hif.id_uses_rt = 1'b1;
        #1;
        checks++;
        if ({dbg_state, hif.pc_we, hif.id_ex_flush} !== 3'b010) begin
            errors++; $display("FAIL loaduse_resume: got %b want 010", {dbg_state, hif.pc_we, hif.id_ex_flush});
        end
        checks++;
        if (stall_cnt !== CNT_W'(exp_stall)) begin
            errors++; $display("FAIL loaduse_cnt: got %0d want %0d", stall_cnt, exp_stall);
        end
        // rt match only counts when the instruction reads rt
        hif.ex_rd = 5'd4; hif.ex_regwrite = 1'b1; hif.ex_memread = 1'b1;
        hif.id_rs = 5'd9; hif.id_rt = 5'd4; hif.id_uses_rt = 1'b0;
        #1;
        checks++;
        if (hif.pc_we !== 1'b1) begin
            errors++; $display("FAIL rt_unused: pc_we got %b want 1", hif.pc_we);
        end
        hif.id_uses_rt = 1'b1;
        #1;
        checks++;
        if (hif.pc_we !== 1'b0) begin
            errors++; $display("FAIL rt_used: pc_we got %b want 0", hif.pc_we);
        end
        // ALU producer in ID/EX is forwarded, no stall
        hif.ex_memread = 1'b0;
        #1;
        checks++;
        if (hif.pc_we !== 1'b1) begin
            errors++; $display("FAIL alu_no_stall: pc_we got %b want 1", hif.pc_we);
        end
        clear_inputs();
        tick();
`else
        // ID/EX rd=7 feeds id_rs=7: two stall cycles
        clear_inputs();
        hif.ex_rd = 5'd7; hif.ex_regwrite = 1'b1; hif.id_rs = 5'd7;
        #1;
        checks++;
        if ({hif.pc_we, hif.if_id_we, hif.id_ex_flush} !== 3'b001) begin
            errors++; $display("FAIL raw2_first: got %b want 001", {hif.pc_we, hif.if_id_we, hif.id_ex_flush});
        end
        tick(); exp_stall++;
        // producer moved on; STALL must not re-evaluate
        clear_inputs();
        hif.id_rs = 5'd7; hif.mem_rd = 5'd7; hif.mem_regwrite = 1'b1;
        hif.id_rs = 5'd1;
        #1;
        checks++;
        if ({dbg_state, dbg_stall_left} !== 3'b101) begin
            errors++; $display("FAIL raw2_enter: state/left got %b want 101", {dbg_state, dbg_stall_left});
        end
        checks++;
        if ({hif.pc_we, hif.if_id_we, hif.id_ex_flush} !== 3'b001) begin
            errors++; $display("FAIL raw2_second: got %b want 001", {hif.pc_we, hif.if_id_we, hif.id_ex_flush});
        end
        tick(); exp_stall++;
        #1;
        checks++;
        if ({dbg_state, hif.pc_we, hif.id_ex_flush} !== 3'b010) begin
            errors++; $display("FAIL raw2_resume: got %b want 010", {dbg_state, hif.pc_we, hif.id_ex_flush});
        end
        checks++;
        if (stall_cnt !== CNT_W'(exp_stall)) begin
            errors++; $display("FAIL raw2_cnt: got %0d want %0d", stall_cnt, exp_stall);
        end
        // EX/MEM producer on rt: one stall cycle, stays in RUN
        clear_inputs();
        hif.mem_rd = 5'd8; hif.mem_regwrite = 1'b1; hif.id_rt = 5'd8; hif.id_uses_rt = 1'b1;
        #1;
        checks++;
        if ({hif.pc_we, hif.id_ex_flush} !== 2'b01) begin
            errors++; $display("FAIL raw1_stall: got %b want 01", {hif.pc_we, hif.id_ex_flush});
        end
        tick(); exp_stall++;
        clear_inputs();
        #1;
        checks++;
        if ({dbg_state, hif.pc_we, stall_cnt} !== {2'b01, CNT_W'(exp_stall)}) begin
            errors++; $display("FAIL raw1_resume: state %b pc_we %b cnt %0d want 0 1 %0d",
                               dbg_state, hif.pc_we, stall_cnt, exp_stall);
        end
        // MEM/WB producer never stalls
        hif.wb_rd = 5'd6; hif.wb_regwrite = 1'b1; hif.id_rs = 5'd6;
        #1;
        checks++;
        if (hif.pc_we !== 1'b1) begin
            errors++; $display("FAIL wb_no_stall: pc_we got %b want 1", hif.pc_we);
        end
        clear_inputs();
        tick();
`endif
    endtask

    task automatic test_forward();
        logic [1:0] exp_hi;
        logic [1:0] exp_lo;
`ifdef PIPE_FORWARD_EN
        exp_hi = 2'b10; exp_lo = 2'b01;
`else
        exp_hi = 2'b00; exp_lo = 2'b00;
`endif
        clear_inputs();
        hif.mem_rd = 5'd5; hif.mem_regwrite = 1'b1;
        hif.wb_rd = 5'd5;  hif.wb_regwrite = 1'b1;
        hif.ex_rs = 5'd5;  hif.ex_rt = 5'd9;
        #1;
        checks++;
        if (hif.fwd_a !== exp_hi) begin
            errors++; $display("FAIL fwd_double: got %b want %b", hif.fwd_a, exp_hi);
        end
        checks++;
        if (hif.fwd_b !== 2'b00) begin
            errors++; $display("FAIL fwd_b_none: got %b want 00", hif.fwd_b);
        end
        hif.mem_regwrite = 1'b0;
        #1;
        checks++;
        if (hif.fwd_a !== exp_lo) begin
            errors++; $display("FAIL fwd_wb_only: got %b want %b", hif.fwd_a, exp_lo);
        end
        hif.mem_regwrite = 1'b1; hif.mem_rd = 5'd9; hif.ex_rt = 5'd9;
        #1;
        checks++;
        if ({hif.fwd_a, hif.fwd_b} !== {exp_lo, exp_hi}) begin
            errors++; $display("FAIL fwd_split: got %b want %b", {hif.fwd_a, hif.fwd_b}, {exp_lo, exp_hi});
        end
        // $0 is never forwarded
        hif.mem_rd = 5'd0; hif.wb_rd = 5'd0; hif.ex_rs = 5'd0; hif.ex_rt = 5'd0;
        #1;
        checks++;
        if ({hif.fwd_a, hif.fwd_b} !== 4'b0000) begin
            errors++; $display("FAIL fwd_zero: got %b want 0000", {hif.fwd_a, hif.fwd_b});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_branch();
        drive_hazard();
`ifndef PIPE_FORWARD_EN
        // get into STALL first
        tick(); exp_stall++;
        clear_inputs();
        #1;
        checks++;
        if (dbg_state !== 1'b1) begin
            errors++; $display("FAIL branch_pre_stall: state got %b want 1", dbg_state);
        end
`endif
        hif.mem_branch_taken = 1'b1;
        #1;
        checks++;
        if ({hif.pc_we, hif.if_id_we, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush} !== 5'b11111) begin
            errors++; $display("FAIL branch_ctrl: got %b want 11111",
                               {hif.pc_we, hif.if_id_we, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush});
        end
        tick(); exp_flush++;
        clear_inputs();
        #1;
        checks++;
        if ({dbg_state, dbg_stall_left} !== 3'b000) begin
            errors++; $display("FAIL branch_state: got %b want 000", {dbg_state, dbg_stall_left});
        end
        checks++;
        if ({flush_cnt, stall_cnt} !== {CNT_W'(exp_flush), CNT_W'(exp_stall)}) begin
            errors++; $display("FAIL branch_cnt: flush %0d stall %0d want %0d %0d",
                               flush_cnt, stall_cnt, exp_flush, exp_stall);
        end
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        hif.ex_rd = 5'd0; hif.ex_regwrite = 1'b1; hif.ex_memread = 1'b1;
        hif.mem_rd = 5'd0; hif.mem_regwrite = 1'b1;
        hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.id_uses_rt = 1'b1;
        #1;
        checks++;
        if ({hif.pc_we, hif.id_ex_flush} !== 2'b10) begin
            errors++; $display("FAIL zero_reg: got %b want 10", {hif.pc_we, hif.id_ex_flush});
        end
        // same match without regwrite never stalls
        hif.ex_rd = 5'd3; hif.id_rs = 5'd3; hif.ex_regwrite = 1'b0; hif.mem_regwrite = 1'b0;
        #1;
        checks++;
        if (hif.pc_we !== 1'b1) begin
            errors++; $display("FAIL no_regwrite: pc_we got %b want 1", hif.pc_we);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drive_hazard();
        tick(); exp_stall++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({hif.pc_we, hif.if_id_we, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush,
             hif.fwd_a, hif.fwd_b} !== 9'b001110000) begin
            errors++; $display("FAIL rst_mid_ctrl: got %b want 001110000",
                               {hif.pc_we, hif.if_id_we, hif.if_id_flush, hif.id_ex_flush,
                                hif.ex_mem_flush, hif.fwd_a, hif.fwd_b});
        end
        checks++;
        if ({stall_cnt, flush_cnt, dbg_state, dbg_stall_left} !== '0) begin
            errors++; $display("FAIL rst_mid_state: stall %0h flush %0h st %b left %0d want all 0",
                               stall_cnt, flush_cnt, dbg_state, dbg_stall_left);
        end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        exp_stall = 0; exp_flush = 0;
        tick();
        checks++;
        if ({dbg_state, hif.pc_we, stall_cnt} !== {2'b01, CNT_W'(0)}) begin
            errors++; $display("FAIL rst_release: state %b pc_we %b cnt %0d want 0 1 0",
                               dbg_state, hif.pc_we, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        drive_hazard();
        repeat (70000) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== {CNT_W{1'b1}}) begin
            errors++; $display("FAIL sat_reach: got %0h want ffff", stall_cnt);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== {CNT_W{1'b1}}) begin
            errors++; $display("FAIL sat_hold: got %0h want ffff", stall_cnt);
        end
        checks++;
        if (flush_cnt !== CNT_W'(0)) begin
            errors++; $display("FAIL sat_flush: got %0h want 0", flush_cnt);
        end
        clear_inputs();
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #2;
        test_reset();
        #10;
        rst_n = 1'b1;          // released at t=12, away from an edge
        tick();
        test_idle();
        test_hazard();
        test_forward();
        test_branch();
        test_zero_reg();
        test_reset_mid_stall();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard detection and pipeline control for the five-stage MIPS pipeline. Reads the outputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives the write-enable and flush controls those registers and the PC consume. Produces the EX-stage operand forwarding selects. Keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- `CNT_W`, 16, width of the stall and flush counters

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction held in IF/ID
- `id_uses_rt`  in  1  the IF/ID instruction reads `rt` (R-type, beq, sw)
- `ex_rs`, `ex_rt`  in  5 each  source registers held in ID/EX
- `ex_rd`  in  5  destination register held in ID/EX
- `ex_regwrite`, `ex_memread`  in  1 each  ID/EX control bits
- `mem_rd`  in  5  destination register held in EX/MEM
- `mem_regwrite`  in  1  EX/MEM control bit
- `wb_rd`  in  5  destination register held in MEM/WB
- `wb_regwrite`  in  1  MEM/WB control bit
- `mem_branch_taken`  in  1  EX/MEM branch AND zero
- `pc_we`  out  1  PC load enable
- `if_id_we`  out  1  IF/ID load enable
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1 each  load a bubble (all zeros) into that register
- `fwd_a`, `fwd_b`  out  2 each  ALU operand source: 00 ID/EX, 10 EX/MEM result, 01 MEM/WB write data
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating event counters

## Operation
- Register $0 never causes a match. A match requires the producer's regwrite bit.
- Register file writes in the first half-cycle, so MEM/WB producers never stall ID.
- The FSM has two states, RUN and STALL, and a 2-bit `stall_left` counter.
- Branch: when `mem_branch_taken`=1 in any state:
  - assert all three flushes;
  - `pc_we`=1 and `if_id_we`=1;
  - force state RUN and `stall_left`=0;
  - `flush_cnt` +1.
  - Branch has priority over every stall.
- RUN with hazard needing N cycles (N from Configuration):
  - `pc_we`=0, `if_id_we`=0, `id_ex_flush`=1;
  - `stall_cnt` +1;
  - if N>1, go to STALL with `stall_left`=N-1; otherwise stay in RUN.
- STALL:
  - same outputs as a RUN stall cycle; inputs are not re-evaluated;
  - `stall_left` decrements each cycle; return to RUN after the cycle where it reaches 1.
- RUN with no hazard: `pc_we`=1, `if_id_we`=1, all flushes 0.
- Counters saturate at all-ones and do not wrap.

## Timing
- All control and forwarding outputs are combinational from the current inputs and state (0-cycle latency).
- State and counters update on the rising edge of `clk`.
- Reset (`rst_n`=0), applied asynchronously:
  - state RUN, `stall_left`=0, counters 0;
  - `pc_we`=0, `if_id_we`=0, all three flushes 1, `fwd_a`=`fwd_b`=00.
- Reset asserted mid-stall abandons the stall. After release the block starts in RUN.

## Configuration
`PIPE_FORWARD_EN` controls forwarding.

Defined:
- Only a load-use hazard stalls, N=1. Load-use: `ex_memread` and `ex_rd` matches `id_rs`, or matches `id_rt` with `id_uses_rt`=1.
- `fwd_a`, using `ex_rs`:
  - 10 if it matches `mem_rd`;
  - else 01 if it matches `wb_rd`;
  - else 00.
- `fwd_b` is formed the same way using `ex_rt`.
- EX/MEM wins a double match.

Undefined:
- `fwd_a` and `fwd_b` are tied to 00.
- Any RAW hazard stalls:
  - an ID/EX producer match gives N=2;
  - otherwise an EX/MEM producer match gives N=1.

## Test plan
- Load-use with forwarding: `lw $2` in ID/EX and `add $3,$2,$4` in IF/ID -> one cycle with `pc_we`=0 and `id_ex_flush`=1, then RUN; `stall_cnt`=1.
- Double forward: `mem_rd`=`wb_rd`=5 and `ex_rs`=5, both regwrite -> `fwd_a`=10; clear `mem_regwrite` -> `fwd_a`=01.
- Without forwarding: ID/EX `rd`=7 matches `id_rs`=7 -> 2 stall cycles, STALL entered with `stall_left`=1; `stall_cnt`=2.
- Branch during STALL: `mem_branch_taken`=1 in the first STALL cycle -> all flushes 1 and `pc_we`=1 that cycle, next state RUN; `flush_cnt`=1.
- `$0` and reset: `ex_rd`=0 with `ex_memread`=1 -> no stall. Drop `rst_n` mid-stall -> outputs take reset values immediately and counters read 0.
- Saturation: hold a load-use hazard for 70000 cycles with `CNT_W`=16 -> `stall_cnt`=0xFFFF and holds.
